// File: rtl/hrm_rot_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hrm_rot_seq
// Description : Sequential harmonic rotator. Steps (sin, cos) from a start
//               angle alpha by a fixed increment delta, N times, using one
//               time-shared signed multiplier over four cycles per step.
//               Optional macro HRM_ROT_SEQ_SAT_EN: saturate instead of wrap
//               when narrowing the accumulators back to W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module hrm_rot_seq #(
  parameter int W      = 25,
  parameter int FRAC   = 23,
  parameter int STEP_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [1:0][W-1:0]     i_alpha,
  input  logic [1:0][W-1:0]     i_delta,
  input  logic [STEP_W-1:0]     i_steps,
  input  logic                  i_ready,
  output logic [1:0][W-1:0]     o_theta,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  // Two guard bits so a sum of two unit-magnitude products never overflows.
  localparam int c_ACC_W = W + 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_M0   = 3'd1,
    S_M1   = 3'd2,
    S_M2   = 3'd3,
    S_M3   = 3'd4,
    S_OUT  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;

  // Index 0 holds the sine term, index 1 the cosine term.
  logic [1:0][W-1:0]          r_theta;
  logic [1:0][W-1:0]          r_delta;
  logic [1:0][W-1:0]          r_out;
  logic [STEP_W-1:0]          r_steps;
  logic [STEP_W-1:0]          r_cnt;
  logic [STEP_W-1:0]          w_cnt_next;

  logic signed [c_ACC_W-1:0]  r_acc_s;
  logic signed [c_ACC_W-1:0]  r_acc_c;
  logic signed [c_ACC_W-1:0]  w_acc_c_fin;
  logic signed [c_ACC_W-1:0]  w_prod;
  logic signed [W-1:0]        w_mul_a;
  logic signed [W-1:0]        w_mul_b;
  logic signed [2*W-1:0]      w_prod_full;
  logic [W-1:0]               w_res_s;
  logic [W-1:0]               w_res_c;

`ifdef HRM_ROT_SEQ_SAT_EN
  localparam logic signed [c_ACC_W-1:0] c_SAT_MAX = c_ACC_W'((2**(W-1)) - 1);
  localparam logic signed [c_ACC_W-1:0] c_SAT_MIN = ~c_SAT_MAX;
`endif

  // Select the operand pair for the single shared multiplier by phase.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_M0: begin w_mul_a = $signed(r_theta[0]); w_mul_b = $signed(r_delta[1]); end
      S_M1: begin w_mul_a = $signed(r_theta[1]); w_mul_b = $signed(r_delta[0]); end
      S_M2: begin w_mul_a = $signed(r_theta[1]); w_mul_b = $signed(r_delta[1]); end
      S_M3: begin w_mul_a = $signed(r_theta[0]); w_mul_b = $signed(r_delta[0]); end
      default: ;
    endcase
  end

  assign w_prod_full = (2*W)'(w_mul_a) * (2*W)'(w_mul_b);
  assign w_prod      = c_ACC_W'(w_prod_full >>> FRAC);
  assign w_acc_c_fin = r_acc_c - w_prod;
  assign w_cnt_next  = r_cnt + STEP_W'(1);

  // Narrow both accumulators back to W bits (cosine uses its final M3 value).
  always_comb begin
    w_res_s = r_acc_s[W-1:0];
    w_res_c = w_acc_c_fin[W-1:0];
`ifdef HRM_ROT_SEQ_SAT_EN
    if (r_acc_s > c_SAT_MAX)          w_res_s = c_SAT_MAX[W-1:0];
    else if (r_acc_s < c_SAT_MIN)     w_res_s = c_SAT_MIN[W-1:0];
    if (w_acc_c_fin > c_SAT_MAX)      w_res_c = c_SAT_MAX[W-1:0];
    else if (w_acc_c_fin < c_SAT_MIN) w_res_c = c_SAT_MIN[W-1:0];
`endif
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic and status outputs.
  always_comb begin
    w_state_next = r_state;
    o_valid      = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_state_next = (i_steps != '0) ? S_M0 : S_DONE;
      end
      S_M0: w_state_next = S_M1;
      S_M1: w_state_next = S_M2;
      S_M2: w_state_next = S_M3;
      S_M3: w_state_next = S_OUT;
      S_OUT: begin
        o_valid = 1'b1;
        if (i_ready) w_state_next = (w_cnt_next == r_steps) ? S_DONE : S_M0;
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_theta = r_out;

  // Datapath: capture on start, multiply-accumulate per phase, publish on M3.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_theta <= '0;
      r_delta <= '0;
      r_out   <= '0;
      r_steps <= '0;
      r_cnt   <= '0;
      r_acc_s <= '0;
      r_acc_c <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && (i_steps != '0)) begin
            r_theta <= i_alpha;
            r_delta <= i_delta;
            r_steps <= i_steps;
            r_cnt   <= '0;
          end
        end
        S_M0: r_acc_s <= w_prod;
        S_M1: r_acc_s <= r_acc_s + w_prod;
        S_M2: r_acc_c <= w_prod;
        S_M3: begin
          r_acc_c <= w_acc_c_fin;
          r_theta <= {w_res_c, w_res_s};
          r_out   <= {w_res_c, w_res_s};
        end
        S_OUT: if (i_ready) r_cnt <= w_cnt_next;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hrm_rot_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hrm_rot_seq
// Description : Directed self-checking bench for hrm_rot_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hrm_rot_seq;

  localparam int W      = 25;
  localparam int STEP_W = 16;

  localparam logic [W-1:0] c_ONE  = 25'h0800000;
  localparam logic [W-1:0] c_MONE = 25'h1800000;
  localparam logic [W-1:0] c_ZERO = 25'h0000000;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [1:0][W-1:0]     alpha;
  logic [1:0][W-1:0]     delta;
  logic [STEP_W-1:0]     steps;
  logic                  ready;
  logic [1:0][W-1:0]     theta;
  logic                  valid;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;

  hrm_rot_seq #(.W(W), .FRAC(23), .STEP_W(STEP_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_alpha (alpha),
    .i_delta (delta),
    .i_steps (steps),
    .i_ready (ready),
    .o_theta (theta),
    .o_valid (valid),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a start pulse; returns at the negedge of cycle 1 (state M0).
  task automatic start_run(input logic [W-1:0] as, input logic [W-1:0] ac,
                           input logic [W-1:0] ds, input logic [W-1:0] dc,
                           input logic [STEP_W-1:0] n);
    @(negedge clk);
    alpha = {ac, as};
    delta = {dc, ds};
    steps = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    alpha = '0;
    delta = '0;
    steps = '0;
    #12;
    checks++; if (theta !== '0)  begin errors++; $display("FAIL reset_theta got=%h exp=0", theta); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Quarter-turn rotation from (0,1) by (1,0), N=4, ready held high.
  task automatic test_basic();
    logic [W-1:0] es [4];
    logic [W-1:0] ec [4];
    logic ev, ed, eb;
    es = '{c_ONE, c_ZERO, c_MONE, c_ZERO};
    ec = '{c_ZERO, c_MONE, c_ZERO, c_ONE};
    ready = 1'b1;
    start_run(c_ZERO, c_ONE, c_ONE, c_ZERO, 16'd4);
    for (int cyc = 1; cyc <= 22; cyc++) begin
      ev = (cyc % 5 == 0) && (cyc <= 20);
      ed = (cyc == 21);
      eb = (cyc <= 21);
      checks++; if (valid !== ev) begin errors++; $display("FAIL basic_valid cyc=%0d got=%b exp=%b", cyc, valid, ev); end
      checks++; if (done !== ed)  begin errors++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", cyc, done, ed); end
      checks++; if (busy !== eb)  begin errors++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", cyc, busy, eb); end
      if (ev) begin
        checks++;
        if (theta[0] !== es[cyc/5-1] || theta[1] !== ec[cyc/5-1]) begin
          errors++;
          $display("FAIL basic_theta cyc=%0d got=(%h,%h) exp=(%h,%h)", cyc, theta[0], theta[1], es[cyc/5-1], ec[cyc/5-1]);
        end
      end
      @(negedge clk);
    end
    checks++; if (theta[0] !== c_ZERO || theta[1] !== c_ONE) begin
      errors++; $display("FAIL basic_theta_kept got=(%h,%h) exp=(%h,%h)", theta[0], theta[1], c_ZERO, c_ONE);
    end
  endtask

  // Same run with downstream stalls; step 2 is held for 7 cycles.
  task automatic test_backpressure();
    logic [W-1:0] es [4];
    logic [W-1:0] ec [4];
    int waitc;
    es = '{c_ONE, c_ZERO, c_MONE, c_ZERO};
    ec = '{c_ZERO, c_MONE, c_ZERO, c_ONE};
    ready = 1'b0;
    start_run(c_ZERO, c_ONE, c_ONE, c_ZERO, 16'd4);
    for (int k = 0; k < 4; k++) begin
      waitc = 0;
      while (valid !== 1'b1 && waitc < 12) begin @(negedge clk); waitc++; end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_timeout step=%0d got=%b exp=1", k, valid); end
      checks++; if (waitc != 4) begin errors++; $display("FAIL bp_latency step=%0d got=%0d exp=4", k, waitc); end
      checks++; if (theta[0] !== es[k] || theta[1] !== ec[k]) begin
        errors++; $display("FAIL bp_theta step=%0d got=(%h,%h) exp=(%h,%h)", k, theta[0], theta[1], es[k], ec[k]);
      end
      if (k == 1) begin
        for (int h = 0; h < 7; h++) begin
          @(negedge clk);
          checks++;
          if (valid !== 1'b1 || theta[0] !== es[1] || theta[1] !== ec[1]) begin
            errors++; $display("FAIL bp_hold cyc=%0d got=(%b,%h,%h) exp=(1,%h,%h)", h, valid, theta[0], theta[1], es[1], ec[1]);
          end
        end
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      if (k < 3) begin
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_valid_clear step=%0d got=%b exp=0", k, valid); end
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got=%b exp=1", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_idle got=(done=%b,busy=%b) exp=(0,0)", done, busy);
    end
  endtask

  // 45 + 45 degrees: sine term reaches 2.0, which wraps or saturates.
  task automatic test_sat();
    logic [W-1:0] exp_s;
    int waitc;
`ifdef HRM_ROT_SEQ_SAT_EN
    exp_s = 25'h0FFFFFF;
`else
    exp_s = 25'h1000000;
`endif
    ready = 1'b1;
    start_run(c_ONE, c_ONE, c_ONE, c_ONE, 16'd1);
    waitc = 0;
    while (valid !== 1'b1 && waitc < 12) begin @(negedge clk); waitc++; end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL sat_timeout got=%b exp=1", valid); end
    checks++; if (theta[0] !== exp_s || theta[1] !== c_ZERO) begin
      errors++; $display("FAIL sat_theta got=(%h,%h) exp=(%h,%h)", theta[0], theta[1], exp_s, c_ZERO);
    end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sat_done got=%b exp=1", done); end
    @(negedge clk);
  endtask

  // N=0: straight to DONE, one busy cycle, no result.
  task automatic test_zero_steps();
    logic [1:0][W-1:0] prev;
    prev  = {c_ZERO, c_ZERO};
    ready = 1'b1;
    start_run(c_ONE, c_ZERO, c_ONE, c_ZERO, 16'd0);
    checks++; if (done !== 1'b1)  begin errors++; $display("FAIL zero_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL zero_busy got=%b exp=1", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL zero_valid got=%b exp=0", valid); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL zero_after got=(done=%b,busy=%b,valid=%b) exp=(0,0,0)", done, busy, valid);
    end
    // o_theta keeps the sat test's result (sine term only; cosine zero)
    checks++; if (theta[1] !== prev[1]) begin errors++; $display("FAIL zero_theta_kept got=%h exp=%h", theta[1], prev[1]); end
  endtask

  // A second start at cycle 3 must not disturb the run in progress.
  task automatic test_restart_ignored();
    logic ev, ed;
    ready = 1'b1;
    start_run(c_ZERO, c_ONE, c_ONE, c_ZERO, 16'd2);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      ev = (cyc == 5) || (cyc == 10);
      ed = (cyc == 11);
      checks++; if (valid !== ev) begin errors++; $display("FAIL rs_valid cyc=%0d got=%b exp=%b", cyc, valid, ev); end
      checks++; if (done !== ed)  begin errors++; $display("FAIL rs_done cyc=%0d got=%b exp=%b", cyc, done, ed); end
      if (cyc == 5) begin
        checks++; if (theta[0] !== c_ONE || theta[1] !== c_ZERO) begin
          errors++; $display("FAIL rs_theta1 got=(%h,%h) exp=(%h,%h)", theta[0], theta[1], c_ONE, c_ZERO);
        end
      end
      if (cyc == 10) begin
        checks++; if (theta[0] !== c_ZERO || theta[1] !== c_MONE) begin
          errors++; $display("FAIL rs_theta2 got=(%h,%h) exp=(%h,%h)", theta[0], theta[1], c_ZERO, c_MONE);
        end
      end
      if (cyc == 3) begin
        alpha = {c_ONE, c_ONE};
        delta = {c_ONE, c_ONE};
        steps = 16'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // Reset during M2 of step 3, then a fresh run from a new start point.
  task automatic test_reset_mid();
    ready = 1'b1;
    start_run(c_ZERO, c_ONE, c_ONE, c_ZERO, 16'd4);
    for (int cyc = 1; cyc < 13; cyc++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (theta !== '0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rm_async got=(%h,%b,%b,%b) exp=(0,0,0,0)", theta, valid, busy, done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rm_no_done cyc=%0d got=%b exp=0", c, done); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    start_run(c_ONE, c_ZERO, c_ONE, c_ZERO, 16'd2);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      if (cyc == 5) begin
        checks++; if (valid !== 1'b1 || theta[0] !== c_ZERO || theta[1] !== c_MONE) begin
          errors++; $display("FAIL rm_theta1 got=(%b,%h,%h) exp=(1,%h,%h)", valid, theta[0], theta[1], c_ZERO, c_MONE);
        end
      end
      if (cyc == 10) begin
        checks++; if (valid !== 1'b1 || theta[0] !== c_MONE || theta[1] !== c_ZERO) begin
          errors++; $display("FAIL rm_theta2 got=(%b,%h,%h) exp=(1,%h,%h)", valid, theta[0], theta[1], c_MONE, c_ZERO);
        end
      end
      if (cyc == 11) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rm_done got=%b exp=1", done); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sat();
    test_zero_steps();
    test_restart_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hrm_rot_seq.md
Name: hrm_rot_seq

Overview:
- Sequential harmonic rotator that drives a single shared 25-bit signed multiplier.
- From a start point (sin α, cos α) and a step (sin δ, cos δ), produces the sequence θk = α + k·δ for k = 1..N.
- Each step uses sin(θ+δ) = sinθ·cosδ + cosθ·sinδ and cos(θ+δ) = cosθ·cosδ − sinθ·sinδ.
- Replaces four parallel multipliers with one multiplier, time-shared over four cycles per step. Sits in the math/hrm area as the low-area NCO/phase-rotator source for downstream sin/cos consumers.

Parameters:
- W, 25, data width; two's complement, Q2.23 (1.0 = 0x0800000).
- FRAC, 23, fraction bits; product is shifted arithmetic-right by FRAC.
- STEP_W, 16, width of the step-count input.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_start  input  1  start pulse; sampled only in IDLE.
- i_alpha  input  W x2  [0]=sin α, [1]=cos α; captured on accepted start.
- i_delta  input  W x2  [0]=sin δ, [1]=cos δ; captured on accepted start.
- i_steps  input  STEP_W  number of outputs N; captured on accepted start.
- i_ready  input  1  downstream accepts o_theta when high with o_valid.
- o_theta  output  W x2  [0]=sin θk, [1]=cos θk.
- o_valid  output  1  o_theta holds a step result.
- o_busy  output  1  high in every state other than IDLE.
- o_done  output  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; o_theta={0,0}; o_valid=0; o_busy=0; o_done=0; step counter=0; accumulators=0.
- Reset asserted mid-operation aborts the sequence immediately; no o_done is produced.
- Arithmetic:
  - One multiplier: p = (a·b) >>> FRAC, computed at 2W bits, then cut to W+2 bits.
  - Accumulators acc_s and acc_c are W+2 bits.
  - Result to W bits follows the Optional Feature rule.
- FSM states: IDLE, M0, M1, M2, M3, OUT, DONE.
- IDLE:
  - On i_start with i_steps != 0: latch α, δ and N; θ := α; go to M0.
  - On i_start with i_steps == 0: go directly to DONE (o_done pulse, no outputs).
- M0: acc_s := sinθ·cosδ.
- M1: acc_s := acc_s + cosθ·sinδ.
- M2: acc_c := cosθ·cosδ.
- M3: acc_c := acc_c − sinθ·sinδ. Next cycle: θ := resize(acc_s, acc_c); o_theta := θ; o_valid=1; state OUT.
- OUT:
  - Hold o_theta and o_valid stable until i_ready.
  - On o_valid && i_ready: count+1. If count == N, go to DONE; otherwise clear o_valid and go to M0.
- DONE: o_done=1 for one cycle, o_valid=0, then IDLE. o_theta keeps its last value.
- Latency: i_start to first o_valid = 5 cycles. Throughput is 1 result per 5 cycles when i_ready is held high.
- i_start while busy is ignored. Inputs are not re-sampled during a sequence.
- i_ready with o_valid low has no effect.
- Step counter wraps only at 2^STEP_W. N = 2^STEP_W−1 is legal.
- Amplitude drift from truncation is not corrected; the user limits N or restarts.

Optional Feature:
- Macro HRM_ROT_SEQ_SAT_EN.
- Defined: resize saturates each accumulator to [−2^(W−1), 2^(W−1)−1], i.e. 0x1000000..0x0FFFFFF.
- Undefined: resize keeps the low W bits (wrap-around). Saves comparators.

Test Plan:
- α=(0, 0x0800000), δ=(0x0800000, 0), N=4, i_ready=1 → outputs (0x0800000,0), (0,0x1800000), (0x1800000,0), (0,0x0800000) at cycles 5, 10, 15, 20; o_done at cycle 21.
- Same as above with i_ready low for 7 cycles at step 2 → o_theta=(0,0x1800000) held stable with o_valid=1 throughout; sequence resumes with no lost or duplicated step.
- α=(0x0800000,0x0800000), δ=(0x0800000,0x0800000), N=1 → with HRM_ROT_SEQ_SAT_EN: (0x0FFFFFF, 0); without it: (0x1000000, 0).
- i_steps=0 with i_start → o_done on the next cycle; o_valid never asserted; o_busy high for exactly 1 cycle.
- i_start pulsed again at cycle 3 of a run → ignored; the run completes with its original α, δ, N.
- i_rst_n low during M2 of step 3 → all outputs return to reset values asynchronously; no o_done; a new i_start after release runs a fresh sequence correctly.
